clock_div_gen: RTL and testbench

- Parametrised, multi-channel successor to the fixed divide-by-2 clock divider.
- Produces NUM_CH independently programmable divided clocks from the single master clock.
- Each channel also outputs a one-cycle tick enable on its rising edge.
- Supports glitch-free runtime ratio changes and a common phase-align sync, so the top level can derive processor, dmem and regfile clocks at arbitrary ratios.

---
 rtl/clock_div_gen.sv | 96 +++++++++
 tb/tb_clock_div_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_gen.sv
// Multi-channel programmable clock divider with per-channel tick enables,
// wrap-synchronised ratio updates and a common phase-align sync.
module clock_div_gen #(
    parameter int NUM_CH        = 4,
    parameter int CNT_WIDTH     = 8,
    parameter int DEFAULT_RATIO = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          sync,
    input  logic                          load,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   div_ratio,
    output logic [NUM_CH-1:0]             clk_out,
    output logic [NUM_CH-1:0]             tick,
    output logic [NUM_CH-1:0]             pending
);

    localparam logic [CNT_WIDTH-1:0] DEF_RATIO = CNT_WIDTH'(DEFAULT_RATIO);
    localparam logic [CNT_WIDTH-1:0] MIN_RATIO = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH:0]   ONE_WIDE  = (CNT_WIDTH+1)'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] active;
        logic [CNT_WIDTH-1:0] shadow;
        logic [CNT_WIDTH-1:0] req;
        logic [CNT_WIDTH-1:0] cnt_next;
        logic [CNT_WIDTH:0]   high;
        logic                 wrap;
        logic                 clk_q;
        logic                 tick_q;
        logic                 pend_q;

        // high is one bit wider so (R+1)>>1 cannot overflow at the top ratio.
        always_comb begin
            req = div_ratio[i*CNT_WIDTH +: CNT_WIDTH];
            if (req < MIN_RATIO) begin
                req = MIN_RATIO;
            end
            cnt_next = (cnt == active - CNT_WIDTH'(1)) ? '0 : cnt + CNT_WIDTH'(1);
            high     = ({1'b0, active} + ONE_WIDE) >> 1;
            wrap     = (cnt_next == '0);
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt    <= '0;
                active <= DEF_RATIO;
                shadow <= DEF_RATIO;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                if (load) begin
                    shadow <= req;
                end
                if (sync) begin
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    pend_q <= 1'b0;
                    if (load) begin
                        active <= req;
                    end else if (pend_q) begin
                        active <= shadow;
                    end
                end else if (enable) begin
                    cnt    <= cnt_next;
                    clk_q  <= ({1'b0, cnt_next} < high);
                    tick_q <= wrap;
                    // A ratio only changes on the wrap edge, so no period is cut short.
                    if (wrap && load) begin
                        active <= req;
                        pend_q <= 1'b0;
                    end else if (wrap && pend_q) begin
                        active <= shadow;
                        pend_q <= 1'b0;
                    end else if (load) begin
                        pend_q <= 1'b1;
                    end
                end else begin
                    tick_q <= 1'b0;
                    if (load) begin
                        pend_q <= 1'b1;
                    end
                end
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clock_div_gen.sv
// Directed self-checking bench for clock_div_gen (NUM_CH=4, CNT_WIDTH=8).
module tb_clock_div_gen;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        sync;
    logic        load;
    logic [31:0] div_ratio;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic [3:0]  pending;

    int errors = 0;
    int checks = 0;

    clock_div_gen #(.NUM_CH(4), .CNT_WIDTH(8), .DEFAULT_RATIO(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .sync      (sync),
        .load      (load),
        .div_ratio (div_ratio),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Outputs are sampled 1ns after the active edge; inputs change there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        sync      = 1'b0;
        load      = 1'b0;
        div_ratio = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        sync      = 1'b0;
        load      = 1'b0;
        div_ratio = '0;
        step();
        step();
        checks++;
        if (clk_out !== 4'h0) begin errors++; $display("FAIL reset_clk: got %h expected %h", clk_out, 4'h0); end
        checks++;
        if (tick !== 4'h0) begin errors++; $display("FAIL reset_tick: got %h expected %h", tick, 4'h0); end
        checks++;
        if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending: got %h expected %h", pending, 4'h0); end
        reset = 1'b0;
    endtask

    task automatic test_default_div2();
        logic [3:0] exp;
        do_reset();
        enable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = (k % 2 == 0) ? 4'hF : 4'h0;
            checks++;
            if (clk_out !== exp) begin errors++; $display("FAIL div2_clk k=%0d: got %h expected %h", k, clk_out, exp); end
            checks++;
            if (tick !== exp) begin errors++; $display("FAIL div2_tick k=%0d: got %h expected %h", k, tick, exp); end
            checks++;
            if (pending !== 4'h0) begin errors++; $display("FAIL div2_pending k=%0d: got %h expected %h", k, pending, 4'h0); end
        end
    endtask

    task automatic test_load_ratio5();
        logic [11:0] exp_clk;
        logic [11:0] exp_tick;
        exp_clk  = 12'b1001_1100_1110;
        exp_tick = 12'b1000_0100_0010;
        do_reset();
        div_ratio = {8'd2, 8'd2, 8'd5, 8'd2};
        load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (pending !== 4'hF) begin errors++; $display("FAIL r5_pending_set: got %h expected %h", pending, 4'hF); end
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (clk_out[1] !== exp_clk[k-1]) begin errors++; $display("FAIL r5_clk k=%0d: got %b expected %b", k, clk_out[1], exp_clk[k-1]); end
            checks++;
            if (tick[1] !== exp_tick[k-1]) begin errors++; $display("FAIL r5_tick k=%0d: got %b expected %b", k, tick[1], exp_tick[k-1]); end
            if (k == 2) begin
                checks++;
                if (pending !== 4'h0) begin errors++; $display("FAIL r5_pending_clr: got %h expected %h", pending, 4'h0); end
            end
        end
    endtask

    task automatic test_mid_period_change();
        logic [15:0] exp_clk;
        logic [15:0] exp_tick;
        logic [15:0] exp_pend;
        exp_clk  = 16'b1011_0110_0001_1110;
        exp_tick = 16'h9202;
        exp_pend = 16'h01F1;
        do_reset();
        div_ratio = {8'd2, 8'd2, 8'd2, 8'd8};
        load = 1'b1;
        step();
        load = 1'b0;
        enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            // Loaded after edge 4, when channel 0 sits at cnt=2.
            if (k == 5) begin
                div_ratio = {8'd2, 8'd2, 8'd2, 8'd3};
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
            checks++;
            if (clk_out[0] !== exp_clk[k-1]) begin errors++; $display("FAIL mid_clk k=%0d: got %b expected %b", k, clk_out[0], exp_clk[k-1]); end
            checks++;
            if (tick[0] !== exp_tick[k-1]) begin errors++; $display("FAIL mid_tick k=%0d: got %b expected %b", k, tick[0], exp_tick[k-1]); end
            checks++;
            if (pending[0] !== exp_pend[k-1]) begin errors++; $display("FAIL mid_pending k=%0d: got %b expected %b", k, pending[0], exp_pend[k-1]); end
        end
        load = 1'b0;
    endtask

    task automatic test_sync_align();
        do_reset();
        div_ratio = {8'd6, 8'd4, 8'd3, 8'd2};
        load = 1'b1;
        step();
        load = 1'b0;
        enable = 1'b1;
        repeat (5) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++;
        if (clk_out !== 4'h0) begin errors++; $display("FAIL sync_clk: got %h expected %h", clk_out, 4'h0); end
        checks++;
        if (tick !== 4'h0) begin errors++; $display("FAIL sync_tick: got %h expected %h", tick, 4'h0); end
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k == 1) begin
                checks++;
                if (clk_out !== 4'b1110) begin errors++; $display("FAIL sync_k1_clk: got %b expected %b", clk_out, 4'b1110); end
            end
            if (k == 4) begin
                checks++;
                if (tick !== 4'b0101) begin errors++; $display("FAIL sync_k4_tick: got %b expected %b", tick, 4'b0101); end
            end
            if (k == 6) begin
                checks++;
                if (tick !== 4'b1011) begin errors++; $display("FAIL sync_k6_tick: got %b expected %b", tick, 4'b1011); end
            end
            if (k == 12 || k == 24) begin
                checks++;
                if (tick !== 4'hF) begin errors++; $display("FAIL sync_align k=%0d: got %h expected %h", k, tick, 4'hF); end
                checks++;
                if (clk_out !== 4'hF) begin errors++; $display("FAIL sync_align_clk k=%0d: got %h expected %h", k, clk_out, 4'hF); end
            end
        end
    endtask

    task automatic test_clamp_and_freeze();
        logic [3:0] exp;
        do_reset();
        div_ratio = {8'd1, 8'd0, 8'd1, 8'd0};
        load = 1'b1;
        sync = 1'b1;
        step();
        load = 1'b0;
        sync = 1'b0;
        checks++;
        if (pending !== 4'h0) begin errors++; $display("FAIL clamp_sync_pending: got %h expected %h", pending, 4'h0); end
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            exp = (k % 2 == 0) ? 4'hF : 4'h0;
            checks++;
            if (clk_out !== exp) begin errors++; $display("FAIL clamp_clk k=%0d: got %h expected %h", k, clk_out, exp); end
        end
        enable = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++;
            if (clk_out !== 4'hF) begin errors++; $display("FAIL freeze_clk k=%0d: got %h expected %h", k, clk_out, 4'hF); end
            checks++;
            if (tick !== 4'h0) begin errors++; $display("FAIL freeze_tick k=%0d: got %h expected %h", k, tick, 4'h0); end
        end
        enable = 1'b1;
        step();
        checks++;
        if (clk_out !== 4'h0) begin errors++; $display("FAIL resume_clk1: got %h expected %h", clk_out, 4'h0); end
        step();
        checks++;
        if (tick !== 4'hF) begin errors++; $display("FAIL resume_tick2: got %h expected %h", tick, 4'hF); end
    endtask

    task automatic test_async_reset();
        do_reset();
        div_ratio = {8'd9, 8'd9, 8'd9, 8'd9};
        load = 1'b1;
        step();
        load = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (clk_out !== 4'hF) begin errors++; $display("FAIL ar_pre_clk: got %h expected %h", clk_out, 4'hF); end
        checks++;
        if (pending !== 4'hF) begin errors++; $display("FAIL ar_pre_pending: got %h expected %h", pending, 4'hF); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (clk_out !== 4'h0) begin errors++; $display("FAIL ar_clk_now: got %h expected %h", clk_out, 4'h0); end
        checks++;
        if (pending !== 4'h0) begin errors++; $display("FAIL ar_pending_now: got %h expected %h", pending, 4'h0); end
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (clk_out !== ((k % 2 == 0) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL ar_default_clk k=%0d: got %h expected %h", k, clk_out, (k % 2 == 0) ? 4'hF : 4'h0);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        sync      = 1'b0;
        load      = 1'b0;
        div_ratio = '0;
        test_reset();
        test_default_div2();
        test_load_ratio5();
        test_mid_period_change();
        test_sync_align();
        test_clamp_and_freeze();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
